// File: rtl/nonce_tx_queue.sv
// rtl/nonce_tx_queue.sv - queues corrected nonces and serialises them MSB-first onto a byte UART handshake.
// Optional duplicate suppression is enabled by defining NONCE_TX_DEDUP_EN.
module nonce_tx_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              nonce_vld,
  input  logic [31:0]       nonce_in,
  input  logic              flush,
  output logic [7:0]        tx_data,
  output logic              tx_vld,
  input  logic              tx_rdy,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic [31:0]       shift;
  logic [1:0]        idx;
  logic              full, empty, pop, dup, wr_en, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign tx_vld  = (state == SEND);
  assign tx_data = shift[31:24];

`ifdef NONCE_TX_DEDUP_EN
  logic [31:0] last_nonce;
  logic        last_vld;

  assign dup = last_vld && (nonce_in == last_nonce);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_nonce <= 32'h0;
      last_vld   <= 1'b0;
    end else if (flush) begin
      last_nonce <= 32'h0;
      last_vld   <= 1'b0;
    end else if (wr_en) begin
      last_nonce <= nonce_in;
      last_vld   <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  assign wr_en = nonce_vld && !flush && !dup && (!full || pop);
  assign drop  = nonce_vld && !flush && !dup && full && !pop;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !flush) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (tx_rdy && (idx == 2'd3)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= nonce_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= wr_ptr;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (drop)  overflow <= 1'b1;
    end
  end

  // Flush never touches the shift register: a frame in flight always completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= 32'h0;
      idx   <= 2'd0;
    end else if (pop) begin
      shift <= mem[rd_ptr[ADDR_W-1:0]];
      idx   <= 2'd0;
    end else if ((state == SEND) && tx_rdy) begin
      shift <= {shift[23:0], 8'h00};
      idx   <= idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_nonce_tx_queue.sv
// tb/tb_nonce_tx_queue.sv - scoreboard bench for nonce_tx_queue.
module tb_nonce_tx_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nonce_vld = 1'b0;
  logic [31:0] nonce_in = 32'h0;
  logic        flush = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy = 1'b0;
  logic [2:0]  level;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];

  nonce_tx_queue #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .nonce_vld(nonce_vld), .nonce_in(nonce_in),
    .flush(flush), .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Bytes transferred on the coming rising edge.
  always @(negedge clk) if (rst_n && tx_vld && tx_rdy) rx.push_back(tx_data);

  task automatic push_frame(input logic [31:0] n);
    exp_q.push_back(n[31:24]); exp_q.push_back(n[23:16]);
    exp_q.push_back(n[15:8]);  exp_q.push_back(n[7:0]);
  endtask

  task automatic strobe(input logic [31:0] n);
    @(posedge clk); #1;
    nonce_vld = 1'b1; nonce_in = n;
    @(posedge clk); #1;
    nonce_vld = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL reset_tx_vld got %b want 0", tx_vld); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] want [4] = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    rx.delete(); exp_q.delete();
    tx_rdy = 1'b1;
    strobe(32'h1234ABCD);
    checks++; if (tx_vld !== 1'b0 || level !== 3'd1) begin errors++; $display("FAIL single_n1 got vld=%b level=%0d want vld=0 level=1", tx_vld, level); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (tx_vld !== 1'b1 || tx_data !== want[i]) begin errors++; $display("FAIL single_byte%0d got vld=%b data=%h want vld=1 data=%h", i, tx_vld, tx_data, want[i]); end
    end
    @(posedge clk); #1;
    checks++; if (tx_vld !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL single_end got vld=%b level=%0d want vld=0 level=0", tx_vld, level); end
  endtask

  task automatic test_backpressure();
    rx.delete(); exp_q.delete();
    tx_rdy = 1'b1;
    push_frame(32'hDEADBEEF);
    strobe(32'hDEADBEEF);
    @(posedge clk); #1;  // byte DE on the wire
    @(posedge clk); #1;  // byte AD on the wire
    tx_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (tx_vld !== 1'b1 || tx_data !== 8'hAD) begin errors++; $display("FAIL bp_hold%0d got vld=%b data=%h want vld=1 data=ad", i, tx_vld, tx_data); end
    end
    tx_rdy = 1'b1;
    repeat (8) @(posedge clk); #1;
    checks++; if (rx.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", rx.size(), exp_q.size()); end
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
      checks++; if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    rx.delete(); exp_q.delete();
    tx_rdy = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 6; k++) begin
      nonce_vld = 1'b1; nonce_in = k;
      if (k <= 5) push_frame(k);
      @(posedge clk); #1;
    end
    nonce_vld = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    tx_rdy = 1'b1;
    repeat (30) @(posedge clk); #1;
    checks++; if (rx.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d want %0d", rx.size(), exp_q.size()); end
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
      checks++; if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b1 || level !== 3'd0) begin errors++; $display("FAIL ovf_after got ovf=%b level=%0d want ovf=1 level=0", overflow, level); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_flush got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    bit seen_idle = 0;
    rx.delete(); exp_q.delete();
    tx_rdy = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      nonce_vld = 1'b1; nonce_in = 32'hA0000000 + k;
      push_frame(32'hA0000000 + k);
      @(posedge clk); #1;
    end
    nonce_vld = 1'b0;
    tx_rdy = 1'b1;
    for (int c = 0; c < 10 && !seen_idle; c++) begin
      @(posedge clk); #1;
      if (!tx_vld) seen_idle = 1;
    end
    checks++; if (!seen_idle) begin errors++; $display("FAIL fp_idle_timeout got no idle want idle within 10 cycles"); end
    nonce_vld = 1'b1; nonce_in = 32'hA0000005;
    push_frame(32'hA0000005);
    @(posedge clk); #1;
    nonce_vld = 1'b0;
    checks++; if (level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fp_level got level=%0d ovf=%b want level=4 ovf=0", level, overflow); end
    repeat (30) @(posedge clk); #1;
    checks++; if (rx.size() !== exp_q.size()) begin errors++; $display("FAIL fp_count got %0d want %0d", rx.size(), exp_q.size()); end
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
      checks++; if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL fp_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush();
    rx.delete(); exp_q.delete();
    tx_rdy = 1'b0;
    push_frame(32'hCAFEF00D);
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      nonce_vld = 1'b1; nonce_in = (k == 0) ? 32'hCAFEF00D : 32'hB0000000 + k;
      @(posedge clk); #1;
    end
    nonce_vld = 1'b0;
    tx_rdy = 1'b1;
    @(posedge clk); #1;
    tx_rdy = 1'b0;
    checks++; if (tx_data !== 8'hFE || overflow !== 1'b1) begin errors++; $display("FAIL fl_pre got data=%h ovf=%b want data=fe ovf=1", tx_data, overflow); end
    flush = 1'b1; nonce_vld = 1'b1; nonce_in = 32'h77777777;
    @(posedge clk); #1;
    flush = 1'b0; nonce_vld = 1'b0;
    checks++; if (level !== 3'd0 || overflow !== 1'b0 || tx_vld !== 1'b1 || tx_data !== 8'hFE) begin
      errors++; $display("FAIL fl_post got level=%0d ovf=%b vld=%b data=%h want level=0 ovf=0 vld=1 data=fe", level, overflow, tx_vld, tx_data);
    end
    tx_rdy = 1'b1;
    repeat (12) @(posedge clk); #1;
    checks++; if (tx_vld !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL fl_end got vld=%b level=%0d want vld=0 level=0", tx_vld, level); end
    checks++; if (rx.size() !== exp_q.size()) begin errors++; $display("FAIL fl_count got %0d want %0d", rx.size(), exp_q.size()); end
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
      checks++; if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL fl_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    rx.delete(); exp_q.delete();
    tx_rdy = 1'b1;
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    strobe(32'h55667788);
    @(posedge clk); #1;  // 55
    @(posedge clk); #1;  // 66
    @(posedge clk); #2;  // 77 on the wire
    rst_n = 1'b0;
    #1;
    checks++; if (tx_vld !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL rst_mid got vld=%b level=%0d want vld=0 level=0", tx_vld, level); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    checks++; if (rx.size() !== exp_q.size()) begin errors++; $display("FAIL rst_count got %0d want %0d", rx.size(), exp_q.size()); end
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
      checks++; if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL rst_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
  endtask

  task automatic test_duplicate();
    rx.delete(); exp_q.delete();
    tx_rdy = 1'b1;
    push_frame(32'h00000042);
`ifndef NONCE_TX_DEDUP_EN
    push_frame(32'h00000042);
`endif
    strobe(32'h00000042);
    strobe(32'h00000042);
    repeat (15) @(posedge clk); #1;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dup_ovf got %b want 0", overflow); end
    checks++; if (rx.size() !== exp_q.size()) begin errors++; $display("FAIL dup_count got %0d want %0d", rx.size(), exp_q.size()); end
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
      checks++; if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL dup_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_flush();
    test_reset_midframe();
    test_duplicate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
